// File: rtl/mac_dot_seq.sv
// mac_dot_seq: sequences signed operand pairs through one MAC, feeding sum_out back as sum_in.
// Optional MAC_DOT_SEQ_BIAS_EN adds cfg_bias as the accumulator start value.
module mac_dot_seq #(
   parameter int DATA_W  = 22,
   parameter int ACC_W   = 48,
   parameter int MAC_LAT = 3,
   parameter int LEN_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  cfg_len,
`ifdef MAC_DOT_SEQ_BIAS_EN
   input  logic [ACC_W-1:0]  cfg_bias,
`endif
   output logic              busy,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_a,
   input  logic [DATA_W-1:0] s_b,
   output logic              mac_i_valid,
   output logic [DATA_W-1:0] mac_a,
   output logic [DATA_W-1:0] mac_b,
   output logic [ACC_W-1:0]  mac_sum_in,
   input  logic              mac_o_valid,
   input  logic [ACC_W-1:0]  mac_sum_out,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [ACC_W-1:0]  m_result,
   output logic              m_err
);
   localparam int TW = $clog2(MAC_LAT + 2);
   typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, DONE} state_t;
   state_t            state;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  acc_init;
   logic [LEN_W-1:0]  remaining;
   logic [TW-1:0]     tmo;
   logic              err;
`ifdef MAC_DOT_SEQ_BIAS_EN
   assign acc_init = cfg_bias;
`else
   assign acc_init = '0;
`endif
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         acc         <= '0;
         remaining   <= '0;
         tmo         <= '0;
         err         <= 1'b0;
         busy        <= 1'b0;
         s_ready     <= 1'b0;
         mac_i_valid <= 1'b0;
         mac_a       <= '0;
         mac_b       <= '0;
         mac_sum_in  <= '0;
         m_valid     <= 1'b0;
         m_result    <= '0;
         m_err       <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               remaining <= cfg_len;
               acc       <= acc_init;
               busy      <= 1'b1;
               err       <= 1'b0;
               s_ready   <= cfg_len != '0;
               state     <= cfg_len == '0 ? DONE : FETCH;
            end
            FETCH: if (s_valid) begin
               mac_a       <= s_a;
               mac_b       <= s_b;
               mac_sum_in  <= acc;
               s_ready     <= 1'b0;
               mac_i_valid <= 1'b1;
               state       <= ISSUE;
            end
            ISSUE: begin
               mac_i_valid <= 1'b0;
               tmo         <= '0;
               state       <= WAIT;
            end
            // A response in the expiry cycle wins over the timeout.
            WAIT: if (mac_o_valid) begin
               acc       <= mac_sum_out;
               remaining <= remaining - 1'b1;
               if (remaining == LEN_W'(1)) begin
                  m_valid  <= 1'b1;
                  m_result <= mac_sum_out;
                  state    <= DONE;
               end else begin
                  s_ready <= 1'b1;
                  state   <= FETCH;
               end
            end else if (tmo == TW'(MAC_LAT)) begin
               err      <= 1'b1;
               m_valid  <= 1'b1;
               m_result <= acc;
               m_err    <= 1'b1;
               state    <= DONE;
            end else begin
               tmo <= tmo + 1'b1;
            end
            DONE: if (m_valid && m_ready) begin
               m_valid <= 1'b0;
               m_err   <= 1'b0;
               err     <= 1'b0;
               busy    <= 1'b0;
               state   <= IDLE;
            end else begin
               m_valid  <= 1'b1;
               m_result <= acc;
               m_err    <= err;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mac_dot_seq.sv
// tb_mac_dot_seq: scoreboard bench for mac_dot_seq with a latency-3 behavioural MAC.
module tb_mac_dot_seq;
   localparam int DATA_W = 22, ACC_W = 48, LEN_W = 8;
   logic clk = 1'b0, rst = 1'b0, start = 1'b0, s_valid = 1'b0, m_ready = 1'b1, late_v = 1'b0;
   logic [LEN_W-1:0] cfg_len = '0;
   logic [ACC_W-1:0] cfg_bias = '0;
   logic [DATA_W-1:0] s_a = '0, s_b = '0, mac_a, mac_b;
   logic [ACC_W-1:0] mac_sum_in, mac_sum_out, m_result;
   logic busy, s_ready, mac_i_valid, mac_o_valid, m_valid, m_err;
   logic [2:0] v = '0;
   logic [ACC_W-1:0] s0 = '0, s1 = '0, s2 = '0;
   int total = 0, passed = 0, cyc = 0, t0 = 0, issues = 0, issue_cyc = 0, drop_at = 0, k;
   bit sr_seen = 0;
   logic [2*DATA_W-1:0] pq[$];
   longint exp_res[$], exp_sin[$];
   bit exp_err[$];

   mac_dot_seq dut (
      .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
`ifdef MAC_DOT_SEQ_BIAS_EN
      .cfg_bias(cfg_bias),
`endif
      .busy(busy), .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
      .mac_i_valid(mac_i_valid), .mac_a(mac_a), .mac_b(mac_b), .mac_sum_in(mac_sum_in),
      .mac_o_valid(mac_o_valid), .mac_sum_out(mac_sum_out),
      .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result), .m_err(m_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Behavioural MAC: o_valid three cycles after i_valid; drop_at suppresses one issue.
   always @(posedge clk) begin
      v  <= {v[1:0], mac_i_valid && (issues != drop_at)};
      s0 <= ACC_W'(longint'($signed(mac_a)) * longint'($signed(mac_b)) + longint'($signed(mac_sum_in)));
      s1 <= s0;
      s2 <= s1;
   end
   assign mac_o_valid = v[2] | late_v;
   assign mac_sum_out = late_v ? ACC_W'(999) : s2;

   always begin
      @(posedge clk);
      if (s_valid && s_ready && pq.size() > 0) void'(pq.pop_front());
      #1;
      s_valid = pq.size() > 0;
      if (pq.size() > 0) {s_a, s_b} = pq[0];
   end

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic fail(input string name);
      total++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   always @(negedge clk) if (rst) begin
      if (s_ready) sr_seen = 1;
      if (mac_i_valid) begin
         issues++;
         issue_cyc = cyc;
         if (exp_sin.size() > 0) chk("sum_in", $signed(mac_sum_in), exp_sin.pop_front());
         else fail("unexpected_issue");
      end
      if (m_valid && m_ready) begin
         if (exp_res.size() > 0) begin
            chk("result", $signed(m_result), exp_res.pop_front());
            chk("err", longint'(m_err), longint'(exp_err.pop_front()));
         end else fail("unexpected_result");
      end
   end

   function automatic void push_pair(input int a, input int b);
      pq.push_back({DATA_W'(a), DATA_W'(b)});
   endfunction

   function automatic void expect_res(input longint r, input bit e);
      exp_res.push_back(r);
      exp_err.push_back(e);
   endfunction

   task automatic start_op(input int len);
      @(posedge clk); #1;
      start = 1'b1; cfg_len = LEN_W'(len); t0 = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_rise(output int kk);
      kk = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (m_valid) begin kk = cyc - t0; break; end
      end
      if (kk < 0) fail("m_valid_wait");
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!busy) return;
      end
      fail("idle_wait");
   endtask

   initial begin
      #2;
      chk("reset_ctl", {busy, s_ready, mac_i_valid, m_valid, m_err}, 0);
      chk("reset_res", m_result, 0);
      @(posedge clk); #1 rst = 1'b1;

      // single pair
      issues = 0; push_pair(256, 512); exp_sin.push_back(0); expect_res(131072, 0);
      start_op(1); wait_rise(k); chk("lat_single", k, 6); wait_idle();
      chk("issues_single", issues, 1);

      // four pairs back-to-back, running sums 0,1,7,-13
      issues = 0;
      push_pair(1, 1); push_pair(2, 3); push_pair(-4, 5); push_pair(10, -10);
      exp_sin.push_back(0); exp_sin.push_back(1); exp_sin.push_back(7); exp_sin.push_back(-13);
      expect_res(-113, 0);
      start_op(4); wait_rise(k); chk("lat_four", k, 21); wait_idle();
      chk("issues_four", issues, 4);

      // zero length
      issues = 0; sr_seen = 0; cfg_bias = ACC_W'('h1000);
`ifdef MAC_DOT_SEQ_BIAS_EN
      expect_res('h1000, 0);
`else
      expect_res(0, 0);
`endif
      start_op(0); wait_rise(k); chk("lat_zero", k, 2); wait_idle();
      chk("issues_zero", issues, 0);
      chk("s_ready_zero", longint'(sr_seen), 0);
`ifdef MAC_DOT_SEQ_BIAS_EN
      issues = 0; push_pair(256, 512); exp_sin.push_back('h1000); expect_res('h21000, 0);
      start_op(1); wait_rise(k); wait_idle();
      chk("issues_bias", issues, 1);
`endif
      cfg_bias = '0;

      // result backpressure with start pulsed while busy
      issues = 0; m_ready = 1'b0; push_pair(3, 4); exp_sin.push_back(0); expect_res(12, 0);
      start_op(1); wait_rise(k);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1 start = ~start; cfg_len = 8'd2;
         @(negedge clk);
         chk("bp_valid", m_valid, 1);
         chk("bp_result", $signed(m_result), 12);
         chk("bp_err", m_err, 0);
         chk("bp_busy", busy, 1);
      end
      @(posedge clk); #1 start = 1'b0; m_ready = 1'b1;
      @(negedge clk); @(negedge clk);
      chk("bp_idle_busy", busy, 0);
      chk("bp_idle_valid", m_valid, 0);
      repeat (3) @(negedge clk);
      chk("bp_start_ignored", busy, 0);
      chk("issues_bp", issues, 1);

      // timeout on the second of three pairs, then a late response in DONE
      issues = 0; drop_at = 2; m_ready = 1'b0;
      push_pair(5, 6); push_pair(7, 8); push_pair(9, 9);
      exp_sin.push_back(0); exp_sin.push_back(30); expect_res(30, 1);
      start_op(3); wait_rise(k);
      chk("tmo_lat", cyc - issue_cyc, 5);
      chk("tmo_err", m_err, 1);
      @(posedge clk); #1 late_v = 1'b1;
      @(posedge clk); #1 late_v = 1'b0;
      @(negedge clk);
      chk("late_ignored", $signed(m_result), 30);
      m_ready = 1'b1; wait_idle();
      chk("issues_tmo", issues, 2);
      pq.delete(); drop_at = 0;

      // asynchronous reset while waiting on the MAC
      issues = 0; push_pair(1, 1); push_pair(2, 2); exp_sin.push_back(0);
      start_op(2);
      for (int i = 0; i < 50 && issues == 0; i++) @(negedge clk);
      @(posedge clk); #3 rst = 1'b0;
      #1;
      chk("rst_ctl", {busy, s_ready, mac_i_valid, m_valid, m_err}, 0);
      chk("rst_data", {mac_a, mac_b}, 0);
      chk("rst_sum", mac_sum_in | m_result, 0);
      pq.delete();
      @(posedge clk); #1 rst = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_late_ignored", {busy, m_valid}, 0);
      push_pair(3, -7); exp_sin.push_back(0); expect_res(-21, 0);
      start_op(1); wait_rise(k); chk("lat_after_rst", k, 6); wait_idle();
      chk("issues_rst", issues, 2);

      chk("sb_drained", exp_res.size() + exp_sin.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
